// File: rtl/afe_thresh_ctrl.sv
// Threshold PWM generator for the AFE: drives VIL/VIH duty pairs and applies
// atomic threshold updates only on period boundaries, then reports settling.
module afe_thresh_ctrl #(
  parameter int              CNT_W    = 10,
  parameter int              LVL_W    = 8,
  parameter logic [LVL_W-1:0] DEF_VIL = 8'h55,
  parameter logic [LVL_W-1:0] DEF_VIH = 8'hAA,
  parameter int              SETTLE_P = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             thr_wr,
  input  logic [LVL_W-1:0] vil_in,
  input  logic [LVL_W-1:0] vih_in,
  output logic             busy,
  output logic             cfg_err,
  output logic             thr_stable,
  output logic [LVL_W-1:0] vil_cur,
  output logic [LVL_W-1:0] vih_cur,
  output logic             period_start,
  output logic             VIL_PWM,
  output logic             VIH_PWM,
  output logic [1:0]       dbg_state
);

  localparam int ST_W = $clog2(SETTLE_P + 1);

  typedef enum logic [1:0] {
    ST_STABLE  = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ST_W-1:0]   r_settle_cnt;
  logic [ST_W-1:0]   w_settle_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [LVL_W-1:0]  r_vil_sh;
  logic [LVL_W-1:0]  r_vih_sh;
  logic [LVL_W-1:0]  r_vil_cur;
  logic [LVL_W-1:0]  r_vih_cur;
  logic              r_cfg_err;
  logic              r_period_start;
  logic              r_vil_pwm;
  logic              r_vih_pwm;
  logic              w_wrap;
  logic              w_busy;
  logic              w_wr_ok;
  logic              w_wr_bad;
  logic              w_apply;
  logic [CNT_W-1:0]  w_vil_thr;
  logic [CNT_W-1:0]  w_vih_thr;

  // thr_wr is a single-cycle strobe with no ready: it is either accepted
  // (busy rises next cycle) or refused with a one-cycle cfg_err pulse.
  assign w_wrap   = (r_cnt == {CNT_W{1'b1}});
  assign w_busy   = (r_state != ST_STABLE);
  assign w_wr_ok  = thr_wr && !w_busy && (vil_in != '0) && (vil_in < vih_in);
  assign w_wr_bad = thr_wr && !w_wr_ok;

  // Level scaled to the counter range: the AFE reads back high_time[CNT_W-1:CNT_W-LVL_W].
  assign w_vil_thr = CNT_W'(r_vil_cur) << (CNT_W - LVL_W);
  assign w_vih_thr = CNT_W'(r_vih_cur) << (CNT_W - LVL_W);

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_apply      = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_wr_ok) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (w_wrap) begin
          w_apply      = 1'b1;
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = '0;
        end
      end
      ST_SETTLE: begin
        if (w_wrap) begin
          if (r_settle_cnt == ST_W'(SETTLE_P - 1)) begin
            w_state_nxt  = ST_STABLE;
            w_settle_nxt = '0;
          end else begin
            w_settle_nxt = r_settle_cnt + ST_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SETTLE;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_vil_sh       <= DEF_VIL;
      r_vih_sh       <= DEF_VIH;
      r_vil_cur      <= DEF_VIL;
      r_vih_cur      <= DEF_VIH;
      r_cfg_err      <= 1'b0;
      r_period_start <= 1'b0;
      r_vil_pwm      <= 1'b0;
      r_vih_pwm      <= 1'b0;
    end else begin
      r_cnt          <= r_cnt + CNT_W'(1);
      r_cfg_err      <= w_wr_bad;
      r_period_start <= (r_cnt == '0);
      r_vil_pwm      <= (r_cnt < w_vil_thr);
      r_vih_pwm      <= (r_cnt < w_vih_thr);
      if (w_wr_ok) begin
        r_vil_sh <= vil_in;
        r_vih_sh <= vih_in;
      end
      // Loaded on the last count so the new duty begins exactly at cnt=0.
      if (w_apply) begin
        r_vil_cur <= r_vil_sh;
        r_vih_cur <= r_vih_sh;
      end
    end
  end

  assign busy         = w_busy;
  assign thr_stable   = (r_state == ST_STABLE);
  assign cfg_err      = r_cfg_err;
  assign vil_cur      = r_vil_cur;
  assign vih_cur      = r_vih_cur;
  assign period_start = r_period_start;
  assign VIL_PWM      = r_vil_pwm;
  assign VIH_PWM      = r_vih_pwm;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_afe_thresh_ctrl.sv
// Bench for afe_thresh_ctrl: directed scenarios plus random writes, checked
// cycle by cycle against a timeline model of periods, applies and settling.
module tb_afe_thresh_ctrl;

  logic       clk;
  logic       rst;
  logic       thr_wr;
  logic [7:0] vil_in;
  logic [7:0] vih_in;
  logic       busy;
  logic       cfg_err;
  logic       thr_stable;
  logic [7:0] vil_cur;
  logic [7:0] vih_cur;
  logic       period_start;
  logic       VIL_PWM;
  logic       VIH_PWM;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  afe_thresh_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .thr_wr       (thr_wr),
    .vil_in       (vil_in),
    .vih_in       (vih_in),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .thr_stable   (thr_stable),
    .vil_cur      (vil_cur),
    .vih_cur      (vih_cur),
    .period_start (period_start),
    .VIL_PWM      (VIL_PWM),
    .VIH_PWM      (VIH_PWM),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: m_k counts clock edges since reset release, so the
  // counter value after edge k is k%1024 and its period index is k/1024.
  int         m_k           = 0;
  int         m_c           = 0;
  int         m_stable_edge = 2048;
  int         m_apply_p     = 0;
  bit         m_pend        = 1'b0;
  logic [7:0] m_vil         = 8'h55;
  logic [7:0] m_vih         = 8'hAA;
  logic [7:0] m_nvil        = 8'h55;
  logic [7:0] m_nvih        = 8'hAA;
  bit         m_vil_pwm     = 1'b0;
  bit         m_vih_pwm     = 1'b0;
  bit         m_ps          = 1'b0;
  bit         m_err         = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0; m_stable_edge = 2048; m_pend = 1'b0;
      m_vil = 8'h55; m_vih = 8'hAA;
      m_vil_pwm = 1'b0; m_vih_pwm = 1'b0; m_ps = 1'b0; m_err = 1'b0;
    end else begin
      m_c       = m_k % 1024;
      m_vil_pwm = (m_c < 4 * int'(m_vil));
      m_vih_pwm = (m_c < 4 * int'(m_vih));
      m_ps      = (m_c == 0);
      m_err     = 1'b0;
      if (thr_wr) begin
        if (m_k < m_stable_edge || vil_in == 8'h00 || vil_in >= vih_in) begin
          m_err = 1'b1;
        end else begin
          m_pend        = 1'b1;
          m_nvil        = vil_in;
          m_nvih        = vih_in;
          m_apply_p     = (m_k + 1) / 1024 + 1;
          m_stable_edge = 1024 * (m_apply_p + 2);
        end
      end
      m_k++;
      if (m_pend && (m_k / 1024) >= m_apply_p) begin
        m_vil  = m_nvil;
        m_vih  = m_nvih;
        m_pend = 1'b0;
      end
    end
  end

  // scoreboard: every output against the model on the falling edge
  always @(negedge clk) begin
    n_checks++;
    if (VIL_PWM !== m_vil_pwm) $display("FAIL mon_vil_pwm k=%0d got %b exp %b", m_k, VIL_PWM, m_vil_pwm);
    else n_pass++;
    n_checks++;
    if (VIH_PWM !== m_vih_pwm) $display("FAIL mon_vih_pwm k=%0d got %b exp %b", m_k, VIH_PWM, m_vih_pwm);
    else n_pass++;
    n_checks++;
    if (period_start !== m_ps) $display("FAIL mon_period_start k=%0d got %b exp %b", m_k, period_start, m_ps);
    else n_pass++;
    n_checks++;
    if (cfg_err !== m_err) $display("FAIL mon_cfg_err k=%0d got %b exp %b", m_k, cfg_err, m_err);
    else n_pass++;
    n_checks++;
    if (busy !== (m_k < m_stable_edge)) $display("FAIL mon_busy k=%0d got %b exp %b", m_k, busy, (m_k < m_stable_edge));
    else n_pass++;
    n_checks++;
    if (thr_stable !== (m_k >= m_stable_edge)) $display("FAIL mon_thr_stable k=%0d got %b exp %b", m_k, thr_stable, (m_k >= m_stable_edge));
    else n_pass++;
    n_checks++;
    if (vil_cur !== m_vil) $display("FAIL mon_vil_cur k=%0d got %h exp %h", m_k, vil_cur, m_vil);
    else n_pass++;
    n_checks++;
    if (vih_cur !== m_vih) $display("FAIL mon_vih_cur k=%0d got %h exp %h", m_k, vih_cur, m_vih);
    else n_pass++;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input int v);
    tick(1);
    while ((m_k % 1024) != v) tick(1);
  endtask

  task automatic wait_stable();
    while (m_k < m_stable_edge) tick(1);
  endtask

  task automatic do_write(input logic [7:0] l, input logic [7:0] h);
    vil_in = l;
    vih_in = h;
    thr_wr = 1'b1;
    tick(1);
    thr_wr = 1'b0;
  endtask

  task automatic test_reset();
    int hl, hh;
    rst = 1'b1; thr_wr = 1'b0; vil_in = 8'h00; vih_in = 8'h00;
    tick(2);
    n_checks++;
    if ({vil_cur, vih_cur} !== 16'h55AA) $display("FAIL rst_levels got %h exp 55aa", {vil_cur, vih_cur});
    else n_pass++;
    n_checks++;
    if ({busy, thr_stable, cfg_err, period_start, VIL_PWM, VIH_PWM} !== 6'b100000)
      $display("FAIL rst_flags got %b exp 100000", {busy, thr_stable, cfg_err, period_start, VIL_PWM, VIH_PWM});
    else n_pass++;
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (period_start !== 1'b1) $display("FAIL rst_first_period_start got %b exp 1", period_start);
    else n_pass++;
    hl = 0; hh = 0;
    repeat (1024) begin
      tick(1);
      hl += int'(VIL_PWM);
      hh += int'(VIH_PWM);
    end
    n_checks++;
    if (hl != 340) $display("FAIL rst_vil_high got %0d exp 340", hl);
    else n_pass++;
    n_checks++;
    if (hh != 680) $display("FAIL rst_vih_high got %0d exp 680", hh);
    else n_pass++;
    while (m_k < 2047) tick(1);
    n_checks++;
    if (thr_stable !== 1'b0) $display("FAIL rst_stable_early got %b exp 0", thr_stable);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({thr_stable, busy} !== 2'b10) $display("FAIL rst_stable_at_2p got %b exp 10", {thr_stable, busy});
    else n_pass++;
  endtask

  task automatic test_update();
    int hl, hh, p;
    wait_stable();
    wait_cnt(500);
    p = m_k / 1024;
    do_write(8'h20, 8'hC0);
    n_checks++;
    if ({busy, cfg_err, vil_cur} !== {2'b10, 8'h55}) $display("FAIL upd_accept got %b/%b/%h exp 1/0/55", busy, cfg_err, vil_cur);
    else n_pass++;
    wait_cnt(1023);
    n_checks++;
    if (vil_cur !== 8'h55) $display("FAIL upd_before_wrap got %h exp 55", vil_cur);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({vil_cur, vih_cur} !== 16'h20C0) $display("FAIL upd_at_wrap got %h exp 20c0", {vil_cur, vih_cur});
    else n_pass++;
    tick(1);
    hl = 0; hh = 0;
    repeat (1024) begin
      tick(1);
      hl += int'(VIL_PWM);
      hh += int'(VIH_PWM);
    end
    n_checks++;
    if (hl != 128 || hh != 768) $display("FAIL upd_high_times got %0d/%0d exp 128/768", hl, hh);
    else n_pass++;
    n_checks++;
    if ((hl >> 2) != 'h20 || (hh >> 2) != 'hC0) $display("FAIL upd_afe_levels got %h/%h exp 20/c0", hl >> 2, hh >> 2);
    else n_pass++;
    while (m_k < (p + 3) * 1024 - 1) tick(1);
    n_checks++;
    if (thr_stable !== 1'b0) $display("FAIL upd_stable_early got %b exp 0", thr_stable);
    else n_pass++;
    tick(1);
    n_checks++;
    if (thr_stable !== 1'b1) $display("FAIL upd_stable_late got %b exp 1", thr_stable);
    else n_pass++;
  endtask

  task automatic test_illegal();
    wait_stable();
    do_write(8'h80, 8'h80);
    n_checks++;
    if ({cfg_err, busy, thr_stable} !== 3'b101) $display("FAIL ill_equal got %b exp 101", {cfg_err, busy, thr_stable});
    else n_pass++;
    tick(1);
    n_checks++;
    if (cfg_err !== 1'b0) $display("FAIL ill_equal_pulse got %b exp 0", cfg_err);
    else n_pass++;
    do_write(8'h00, 8'h40);
    n_checks++;
    if ({cfg_err, busy} !== 2'b10) $display("FAIL ill_zero got %b exp 10", {cfg_err, busy});
    else n_pass++;
    tick(1);
    do_write(8'h90, 8'h10);
    n_checks++;
    if (cfg_err !== 1'b1) $display("FAIL ill_inverted got %b exp 1", cfg_err);
    else n_pass++;
    wait_cnt(1);
    n_checks++;
    if ({vil_cur, vih_cur, thr_stable} !== {16'h20C0, 1'b1}) $display("FAIL ill_unchanged got %h/%b exp 20c0/1", {vil_cur, vih_cur}, thr_stable);
    else n_pass++;
  endtask

  task automatic test_busy();
    wait_stable();
    do_write(8'h30, 8'h90);
    tick(3);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_set got %b exp 1", busy);
    else n_pass++;
    do_write(8'h10, 8'h20);
    n_checks++;
    if (cfg_err !== 1'b1) $display("FAIL busy_reject got %b exp 1", cfg_err);
    else n_pass++;
    wait_stable();
    n_checks++;
    if ({vil_cur, vih_cur} !== 16'h3090) $display("FAIL busy_first_kept got %h exp 3090", {vil_cur, vih_cur});
    else n_pass++;
  endtask

  task automatic test_extremes();
    int hl, hh, rl, rh;
    logic pl, ph;
    do_write(8'h01, 8'hFF);
    wait_stable();
    hl = 0; hh = 0; rl = 0; rh = 0;
    pl = VIL_PWM; ph = VIH_PWM;
    repeat (1024) begin
      tick(1);
      hl += int'(VIL_PWM);
      hh += int'(VIH_PWM);
      if (VIL_PWM && !pl) rl++;
      if (VIH_PWM && !ph) rh++;
      pl = VIL_PWM; ph = VIH_PWM;
    end
    n_checks++;
    if (hl != 4 || hh != 1020) $display("FAIL ext_high_times got %0d/%0d exp 4/1020", hl, hh);
    else n_pass++;
    n_checks++;
    if (rl != 1 || rh != 1) $display("FAIL ext_rising_edges got %0d/%0d exp 1/1", rl, rh);
    else n_pass++;
  endtask

  task automatic test_boundary();
    wait_stable();
    wait_cnt(1023);
    do_write(8'h40, 8'h80);
    n_checks++;
    if ({busy, vil_cur, vih_cur} !== {1'b1, 16'h01FF}) $display("FAIL bnd_no_early_apply got %b/%h exp 1/01ff", busy, {vil_cur, vih_cur});
    else n_pass++;
    wait_cnt(1023);
    n_checks++;
    if (vil_cur !== 8'h01) $display("FAIL bnd_hold got %h exp 01", vil_cur);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({vil_cur, vih_cur} !== 16'h4080) $display("FAIL bnd_apply got %h exp 4080", {vil_cur, vih_cur});
    else n_pass++;
    wait_stable();
  endtask

  task automatic test_reset_mid();
    int hl, hh;
    do_write(8'h11, 8'h22);
    tick(3);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rmid_pending got %b exp 1", busy);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({vil_cur, vih_cur} !== 16'h55AA) $display("FAIL rmid_levels got %h exp 55aa", {vil_cur, vih_cur});
    else n_pass++;
    n_checks++;
    if ({busy, thr_stable, cfg_err, period_start, VIL_PWM, VIH_PWM} !== 6'b100000)
      $display("FAIL rmid_flags got %b exp 100000", {busy, thr_stable, cfg_err, period_start, VIL_PWM, VIH_PWM});
    else n_pass++;
    tick(1);
    rst = 1'b0;
    wait_cnt(1023);
    tick(2);
    n_checks++;
    if ({vil_cur, vih_cur} !== 16'h55AA) $display("FAIL rmid_shadow_dropped got %h exp 55aa", {vil_cur, vih_cur});
    else n_pass++;
    hl = 0; hh = 0;
    repeat (1024) begin
      tick(1);
      hl += int'(VIL_PWM);
      hh += int'(VIH_PWM);
    end
    n_checks++;
    if (hl != 340 || hh != 680) $display("FAIL rmid_high_times got %0d/%0d exp 340/680", hl, hh);
    else n_pass++;
  endtask

  task automatic test_random();
    int l, h;
    repeat (8) begin
      tick($urandom_range(0, 1500));
      if ($urandom_range(0, 3) == 0) begin
        l = $urandom_range(0, 255);
        h = $urandom_range(0, 255);
      end else begin
        l = $urandom_range(1, 254);
        h = $urandom_range(l + 1, 255);
      end
      do_write(8'(l), 8'(h));
      n_checks++;
      if (cfg_err !== m_err) $display("FAIL rnd_cfg_err vil=%h vih=%h got %b exp %b", l[7:0], h[7:0], cfg_err, m_err);
      else n_pass++;
    end
    wait_stable();
    tick(1030);
  endtask

  initial begin
    rst = 1'b1; thr_wr = 1'b0; vil_in = 8'h00; vih_in = 8'h00;
    test_reset();
    test_update();
    test_illegal();
    test_busy();
    test_extremes();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
